ram_ctrl: RTL and testbench

RAM_CTRL -- requirements
Module: ram_ctrl

---
 rtl/ram_ctrl_pkg.sv | 16 +
 rtl/ram_ctrl.sv | 131 +++++++++++++
 tb/tb_ram_ctrl.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_ctrl_pkg.sv
// Shared types and default sizes for the RAM controller.
package ram_ctrl_pkg;

   localparam int DATA_WIDTH_DEF = 16;
   localparam int ADDR_WIDTH_DEF = 8;

   typedef enum logic [2:0] {
      INIT = 3'd0,
      IDLE = 3'd1,
      WR   = 3'd2,
      RD1  = 3'd3,
      RD2  = 3'd4,
      RSP  = 3'd5
   } state_t;

endpackage

// File: rtl/ram_ctrl.sv
// Valid/ready front end to an asynchronous SRAM with a shared tri-state data bus.
// Define RAM_CTRL_INIT_EN to zero-fill the whole RAM after every reset.
module ram_ctrl
   import ram_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic [ADDR_WIDTH-1:0] ram_address,
   inout  wire  [DATA_WIDTH-1:0] ram_data,
   output logic                  ram_cs,
   output logic                  ram_we,
   output logic                  ram_oe
);

   state_t                state;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic                  drive;

`ifdef RAM_CTRL_INIT_EN
   localparam state_t RST_STATE = INIT;
   logic [ADDR_WIDTH-1:0] init_cnt;
`else
   localparam state_t RST_STATE = IDLE;
`endif

   // drive is only ever set together with ram_we, so a read never sees contention
   assign ram_data = drive ? wdata_q : 'z;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= RST_STATE;
         req_ready   <= 1'b0;
         rsp_valid   <= 1'b0;
         rsp_rdata   <= '0;
         ram_address <= '0;
         ram_cs      <= 1'b0;
         ram_we      <= 1'b0;
         ram_oe      <= 1'b0;
         drive       <= 1'b0;
         wdata_q     <= '0;
`ifdef RAM_CTRL_INIT_EN
         init_cnt    <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (req_valid && req_ready) begin
                  ram_address <= req_addr;
                  wdata_q     <= req_wdata;
                  req_ready   <= 1'b0;
                  ram_cs      <= 1'b1;
                  if (req_we) begin
                     state  <= WR;
                     ram_we <= 1'b1;
                     drive  <= 1'b1;
                  end else begin
                     state  <= RD1;
                     ram_oe <= 1'b1;
                  end
               end else begin
                  req_ready <= 1'b1;
               end
            end
            WR: begin
               state     <= IDLE;
               ram_cs    <= 1'b0;
               ram_we    <= 1'b0;
               drive     <= 1'b0;
               req_ready <= 1'b1;
            end
            RD1: state <= RD2;
            RD2: begin
               rsp_rdata <= ram_data;
               rsp_valid <= 1'b1;
               ram_cs    <= 1'b0;
               ram_oe    <= 1'b0;
               state     <= RSP;
            end
            RSP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  req_ready <= 1'b1;
                  state     <= IDLE;
               end
            end
`ifdef RAM_CTRL_INIT_EN
            // ram_we doubles as the phase bit: one strobe cycle, one idle cycle
            INIT: begin
               if (!ram_we) begin
                  ram_address <= init_cnt;
                  wdata_q     <= '0;
                  ram_cs      <= 1'b1;
                  ram_we      <= 1'b1;
                  drive       <= 1'b1;
               end else begin
                  ram_cs   <= 1'b0;
                  ram_we   <= 1'b0;
                  drive    <= 1'b0;
                  init_cnt <= init_cnt + 1'b1;
                  if (init_cnt == '1) begin
                     state     <= IDLE;
                     req_ready <= 1'b1;
                  end
               end
            end
`endif
            default: begin
               state     <= IDLE;
               req_ready <= 1'b0;
               ram_cs    <= 1'b0;
               ram_we    <= 1'b0;
               ram_oe    <= 1'b0;
               drive     <= 1'b0;
               rsp_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ram_ctrl.sv
// Bench for ram_ctrl: SRAM model on the tri-state bus, expected-contents array, bus monitor.
module tb_ram_ctrl;

   localparam int DW    = 16;
   localparam int AW    = 8;
   localparam int DEPTH = 1 << AW;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          req_valid = 1'b0;
   logic          req_we = 1'b0;
   logic [AW-1:0] req_addr = '0;
   logic [DW-1:0] req_wdata = '0;
   logic          rsp_ready = 1'b0;
   logic          req_ready, rsp_valid, ram_cs, ram_we, ram_oe;
   logic [DW-1:0] rsp_rdata;
   logic [AW-1:0] ram_address;
   wire  [DW-1:0] ram_data;

   logic [DW-1:0] mem     [DEPTH];
   logic [DW-1:0] exp_mem [DEPTH];
   int tests = 0, fails = 0, viol = 0, timeouts = 0;

   ram_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .ram_address(ram_address), .ram_data(ram_data),
      .ram_cs(ram_cs), .ram_we(ram_we), .ram_oe(ram_oe)
   );

   always #5 clk = ~clk;

   // asynchronous SRAM: drives on read, stores at the edge that ends a write strobe
   assign ram_data = (ram_cs && ram_oe && !ram_we) ? mem[ram_address] : 'z;
   initial begin
      for (int i = 0; i < DEPTH; i++) mem[i] = '0;
      forever begin
         @(posedge clk);
         if (ram_cs && ram_we) mem[ram_address] = ram_data;
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         if (ram_we && ram_oe) viol++;
         if (ram_cs && ram_oe && !ram_we && ram_data !== mem[ram_address]) viol++;
      end
   end

   task automatic clear_expected();
`ifdef RAM_CTRL_INIT_EN
      for (int i = 0; i < DEPTH; i++) exp_mem[i] = '0;
`endif
   endtask

   task automatic wait_ready();
      int n = 0;
      @(negedge clk);
      while (!req_ready && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) timeouts++;
   endtask

   task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
      wait_ready();
      req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d;
      @(posedge clk); #1;
      req_valid = 1'b0; req_addr = AW'($urandom); req_wdata = DW'($urandom);
      exp_mem[a] = d;
   endtask

   // lat counts edges from the acceptance edge (1) to the edge after which rsp_valid is seen
   task automatic do_read(input logic [AW-1:0] a, output logic [DW-1:0] d, output int lat);
      bit got = 1'b0;
      wait_ready();
      req_valid = 1'b1; req_we = 1'b0; req_addr = a;
      @(posedge clk); #1;
      req_valid = 1'b0; req_addr = AW'($urandom); req_wdata = DW'($urandom);
      lat = 1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (rsp_valid) begin got = 1'b1; break; end
         @(posedge clk);
         lat++;
      end
      d = rsp_rdata;
      if (!got) timeouts++;
   endtask

   task automatic take_rsp();
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      tests++;
      if ({req_ready, rsp_valid, ram_cs, ram_we, ram_oe} !== 5'b0) begin
         fails++; $display("FAIL reset_ctrl got=%b exp=00000", {req_ready, rsp_valid, ram_cs, ram_we, ram_oe});
      end
      tests++;
      if (rsp_rdata !== '0) begin fails++; $display("FAIL reset_rdata got=%h exp=0000", rsp_rdata); end
      tests++;
      if (ram_address !== '0) begin fails++; $display("FAIL reset_addr got=%h exp=00", ram_address); end
      rst_n = 1'b1;
      clear_expected();
`ifndef RAM_CTRL_INIT_EN
      #1;
      tests++;
      if (req_ready !== 1'b0) begin fails++; $display("FAIL ready_before_edge got=%b exp=0", req_ready); end
      @(negedge clk);
      tests++;
      if (req_ready !== 1'b1) begin fails++; $display("FAIL ready_after_edge got=%b exp=1", req_ready); end
`endif
   endtask

   task automatic test_write_read();
      logic [DW-1:0] d; int lat;
      do_write(8'h10, 16'hA5A5);
      do_read(8'h10, d, lat);
      tests++;
      if (d !== 16'hA5A5) begin fails++; $display("FAIL wr_rd_data got=%h exp=a5a5", d); end
      tests++;
      if (lat !== 3) begin fails++; $display("FAIL rd_latency got=%0d exp=3", lat); end
      take_rsp();
   endtask

   task automatic test_backpressure();
      logic [DW-1:0] d; int lat, bad;
      do_write(8'h20, DW'($urandom));
      do_read(8'h20, d, lat);
      tests++;
      if (d !== exp_mem[8'h20]) begin fails++; $display("FAIL bp_data got=%h exp=%h", d, exp_mem[8'h20]); end
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); @(negedge clk);
         if (rsp_valid !== 1'b1 || rsp_rdata !== exp_mem[8'h20] || req_ready !== 1'b0) bad++;
      end
      tests++;
      if (bad != 0) begin fails++; $display("FAIL bp_hold got=%0d unstable cycles exp=0", bad); end
      take_rsp();
      @(negedge clk);
      tests++;
      if ({rsp_valid, req_ready} !== 2'b01) begin
         fails++; $display("FAIL bp_release got=%b exp=01", {rsp_valid, req_ready});
      end
   endtask

   task automatic test_back_to_back();
      logic [3:0] r; logic [DW-1:0] d; int lat;
      wait_ready();
      r[3] = req_ready;
      req_valid = 1'b1; req_we = 1'b1; req_addr = 8'hFF; req_wdata = 16'h1234;
      @(negedge clk); r[2] = req_ready; req_addr = 8'h00; req_wdata = 16'h5678;
      @(negedge clk); r[1] = req_ready;
      @(negedge clk); r[0] = req_ready; req_valid = 1'b0;
      exp_mem[8'hFF] = 16'h1234; exp_mem[8'h00] = 16'h5678;
      tests++;
      if (r !== 4'b1010) begin fails++; $display("FAIL b2b_ready got=%b exp=1010", r); end
      do_read(8'hFF, d, lat); take_rsp();
      tests++;
      if (d !== 16'h1234) begin fails++; $display("FAIL b2b_rd_ff got=%h exp=1234", d); end
      do_read(8'h00, d, lat); take_rsp();
      tests++;
      if (d !== 16'h5678) begin fails++; $display("FAIL b2b_rd_00 got=%h exp=5678", d); end
   endtask

   task automatic test_random();
      logic [DW-1:0] d; logic [AW-1:0] a; int lat;
      for (int i = 0; i < 40; i++) begin
         a = AW'($urandom);
         if ($urandom_range(1, 0) == 1) do_write(a, DW'($urandom));
         else begin
            do_read(a, d, lat);
            repeat ($urandom_range(3, 0)) @(posedge clk);
            take_rsp();
            tests++;
            if (d !== exp_mem[a] || lat !== 3) begin
               fails++; $display("FAIL rand_rd a=%h got=%h/%0d exp=%h/3", a, d, lat, exp_mem[a]);
            end
         end
      end
   endtask

   task automatic test_reset_abort();
      logic [DW-1:0] d, v; int lat, seen;
      do_write(8'h30, DW'($urandom));
      wait_ready();
      req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h30;
      @(posedge clk); #1;
      req_valid = 1'b0;
      rst_n = 1'b0; #1;
      tests++;
      if ({ram_cs, ram_we, ram_oe, rsp_valid} !== 4'b0) begin
         fails++; $display("FAIL abort_rd_strobes got=%b exp=0000", {ram_cs, ram_we, ram_oe, rsp_valid});
      end
      @(negedge clk); rst_n = 1'b1; clear_expected();
      seen = 0;
      for (int i = 0; i < 10; i++) begin @(negedge clk); if (rsp_valid) seen++; end
      tests++;
      if (seen != 0) begin fails++; $display("FAIL abort_rd_rsp got=%0d responses exp=0", seen); end
      // a write cut off by reset must leave the old contents in place
      v = exp_mem[8'h31] ^ 16'h5A5B;
      wait_ready();
      req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h31; req_wdata = v;
      @(posedge clk); #1;
      req_valid = 1'b0;
      rst_n = 1'b0;
      @(negedge clk); rst_n = 1'b1; clear_expected();
      do_read(8'h31, d, lat); take_rsp();
      tests++;
      if (d !== exp_mem[8'h31]) begin fails++; $display("FAIL abort_wr got=%h exp=%h", d, exp_mem[8'h31]); end
   endtask

`ifdef RAM_CTRL_INIT_EN
   task automatic test_init();
      logic [DW-1:0] d; int lat, n;
      do_write(8'h7F, 16'hFFFF);
      @(negedge clk); rst_n = 1'b0;
      @(negedge clk); rst_n = 1'b1; clear_expected();
      n = 0;
      while (!req_ready && n < 2000) begin @(negedge clk); n++; end
      tests++;
      if (n != 2 * DEPTH) begin fails++; $display("FAIL init_busy got=%0d exp=%0d", n, 2 * DEPTH); end
      do_read(8'h7F, d, lat); take_rsp();
      tests++;
      if (d !== 16'h0000) begin fails++; $display("FAIL init_clear got=%h exp=0000", d); end
   endtask
`endif

   initial begin
      for (int i = 0; i < DEPTH; i++) exp_mem[i] = '0;
      test_reset();
      test_write_read();
      test_backpressure();
      test_back_to_back();
      test_random();
      test_reset_abort();
`ifdef RAM_CTRL_INIT_EN
      test_init();
`endif
      repeat (2) @(negedge clk);
      tests++;
      if (viol != 0) begin fails++; $display("FAIL bus_monitor got=%0d violations exp=0", viol); end
      tests++;
      if (timeouts != 0) begin fails++; $display("FAIL handshake_timeout got=%0d exp=0", timeouts); end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
